// File: rtl/pipe_pkg.sv
// Shared constants, pipeline tag type and match helpers for the RV32 hazard/forwarding controller.
package pipe_pkg;

   localparam int         XLEN        = 32;
   localparam int         REG_AW      = 5;
   localparam logic [2:0] FWD_SEL_RAW = 3'd0;

   typedef struct packed {
      logic              valid;
      logic              we;
      logic              is_load;
      logic [REG_AW-1:0] rd;
   } pipe_tag_t;

   // x0 is hard-wired zero, so a source index of 0 never matches a producer.
   function automatic logic rs_match(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs);
      return (rd == rs) && (rs != '0);
   endfunction

   function automatic logic load_hit(input pipe_tag_t t,
                                     input logic [REG_AW-1:0] rs1,
                                     input logic [REG_AW-1:0] rs2);
      return t.valid && t.we && t.is_load && (t.rd != '0) && ((t.rd == rs1) || (t.rd == rs2));
   endfunction

endpackage

// File: rtl/fwd_mux.sv
// Priority operand select for one EX source: the youngest tracked stage that writes rs wins.
module fwd_mux #(
   parameter int XLEN      = 32,
   parameter int REG_AW    = 5,
   parameter int FWD_DEPTH = 3
) (
   input  logic [REG_AW-1:0]           i_rs,
   input  logic [XLEN-1:0]             i_raw,
   input  logic [FWD_DEPTH-1:0]        i_vld,
   input  logic [FWD_DEPTH*REG_AW-1:0] i_rd,
   input  logic [FWD_DEPTH*XLEN-1:0]   i_stage_res,
   output logic [2:0]                  o_sel,
   output logic [XLEN-1:0]             o_data
);
   import pipe_pkg::*;

   // Walk oldest to youngest so the last hit (nearest stage) overrides.
   always_comb begin
      o_sel  = FWD_SEL_RAW;
      o_data = i_raw;
      for (int k = FWD_DEPTH; k >= 1; k--) begin
         if (i_vld[k-1] && rs_match(i_rd[(k-1)*REG_AW +: REG_AW], i_rs)) begin
            o_sel  = 3'(k);
            o_data = i_stage_res[k*XLEN-1 -: XLEN];
         end
      end
   end

endmodule

// File: rtl/pipe_hazard_fwd.sv
// Hazard/forwarding controller for the 5-stage RV32 pipeline: operand forwarding, load-use stall, branch squash.
// Build option HAZ_STATS_EN adds saturating stall/flush cycle counters (o_stall_cnt, o_flush_cnt).
module pipe_hazard_fwd #(
   parameter int XLEN       = pipe_pkg::XLEN,
   parameter int REG_AW     = pipe_pkg::REG_AW,
   parameter int FWD_DEPTH  = 3,
   parameter int LOAD_STAGE = 2,
   parameter int BR_FLUSH   = 2
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_id_valid,
   input  logic [REG_AW-1:0]         i_id_rs1,
   input  logic [REG_AW-1:0]         i_id_rs2,
   input  logic [REG_AW-1:0]         i_id_rd,
   input  logic                      i_id_we,
   input  logic                      i_id_is_load,
   input  logic [XLEN-1:0]           i_ex_rs1_raw,
   input  logic [XLEN-1:0]           i_ex_rs2_raw,
   input  logic [FWD_DEPTH*XLEN-1:0] i_stage_res,
   input  logic                      i_br_taken,
   output logic                      o_stall,
   output logic                      o_flush,
   output logic [XLEN-1:0]           o_ex_rs1_fwd,
   output logic [XLEN-1:0]           o_ex_rs2_fwd,
   output logic [2:0]                o_fwd_sel1,
   output logic [2:0]                o_fwd_sel2
`ifdef HAZ_STATS_EN
   ,
   output logic [31:0]               o_stall_cnt,
   output logic [31:0]               o_flush_cnt
`endif
);
   import pipe_pkg::*;

   localparam int CNT_W = 2;

   pipe_tag_t                  r_ex_tag;
   logic [REG_AW-1:0]          r_ex_rs1;
   logic [REG_AW-1:0]          r_ex_rs2;
   pipe_tag_t                  r_trk [FWD_DEPTH];
   logic [CNT_W-1:0]           r_squash_cnt;

   logic                       w_load_use;
   logic                       w_flush;
   logic                       w_capture;
   logic [FWD_DEPTH-1:0]       w_fwd_vld;
   logic [FWD_DEPTH*REG_AW-1:0] w_fwd_rd;

   // A load is unusable until LOAD_STAGE, so it blocks ID from EX and every tracked stage before that.
   always_comb begin
      w_load_use = (LOAD_STAGE >= 2) && load_hit(r_ex_tag, i_id_rs1, i_id_rs2);
      for (int k = 1; k <= LOAD_STAGE - 2 && k <= FWD_DEPTH; k++) begin
         if (load_hit(r_trk[k-1], i_id_rs1, i_id_rs2)) begin
            w_load_use = 1'b1;
         end
      end
      w_load_use = w_load_use & i_id_valid;
   end

   // Squash wins over stall: a wrong-path load never needs its consumer held.
   assign w_flush   = ~i_reset & (i_br_taken | (r_squash_cnt != '0));
   assign o_flush   = w_flush;
   assign o_stall   = ~i_reset & w_load_use & ~w_flush;
   assign w_capture = i_id_valid & ~o_stall & ~w_flush;

   always_comb begin
      w_fwd_vld = '0;
      w_fwd_rd  = '0;
      for (int k = 0; k < FWD_DEPTH; k++) begin
         w_fwd_vld[k]                  = r_trk[k].valid & r_trk[k].we;
         w_fwd_rd[k*REG_AW +: REG_AW]  = r_trk[k].rd;
      end
   end

   // ---- ID -> EX capture, EX -> tracked stages shift, branch squash countdown ----
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_ex_tag     <= '0;
         r_squash_cnt <= '0;
         for (int k = 0; k < FWD_DEPTH; k++) begin
            r_trk[k] <= '0;
         end
      end else begin
         if (w_capture) begin
            r_ex_tag.valid   <= 1'b1;
            r_ex_tag.we      <= i_id_we;
            r_ex_tag.is_load <= i_id_is_load;
            r_ex_tag.rd      <= i_id_rd;
         end else begin
            r_ex_tag <= '0;
         end
         r_trk[0] <= r_ex_tag;
         for (int k = 1; k < FWD_DEPTH; k++) begin
            r_trk[k] <= r_trk[k-1];
         end
         if (i_br_taken) begin
            r_squash_cnt <= CNT_W'(BR_FLUSH - 1);
         end else if (r_squash_cnt != '0) begin
            r_squash_cnt <= r_squash_cnt - 1'b1;
         end
      end
   end

   // Source indices are data-path only; bubbles carry x0 so nothing forwards into an empty slot.
   always_ff @(posedge i_clk) begin
      r_ex_rs1 <= w_capture ? i_id_rs1 : '0;
      r_ex_rs2 <= w_capture ? i_id_rs2 : '0;
   end

   // ---- EX operand forwarding ----
   fwd_mux #(
      .XLEN      (XLEN),
      .REG_AW    (REG_AW),
      .FWD_DEPTH (FWD_DEPTH)
   ) u_fwd_rs1 (
      .i_rs        (r_ex_rs1),
      .i_raw       (i_ex_rs1_raw),
      .i_vld       (w_fwd_vld),
      .i_rd        (w_fwd_rd),
      .i_stage_res (i_stage_res),
      .o_sel       (o_fwd_sel1),
      .o_data      (o_ex_rs1_fwd)
   );

   fwd_mux #(
      .XLEN      (XLEN),
      .REG_AW    (REG_AW),
      .FWD_DEPTH (FWD_DEPTH)
   ) u_fwd_rs2 (
      .i_rs        (r_ex_rs2),
      .i_raw       (i_ex_rs2_raw),
      .i_vld       (w_fwd_vld),
      .i_rd        (w_fwd_rd),
      .i_stage_res (i_stage_res),
      .o_sel       (o_fwd_sel2),
      .o_data      (o_ex_rs2_fwd)
   );

`ifdef HAZ_STATS_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   logic [31:0] r_stall_tot;
   logic [31:0] r_flush_tot;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_stall_tot <= '0;
         r_flush_tot <= '0;
      end else begin
         if (o_stall) r_stall_tot <= sat_inc(r_stall_tot);
         if (o_flush) r_flush_tot <= sat_inc(r_flush_tot);
      end
   end

   assign o_stall_cnt = r_stall_tot;
   assign o_flush_cnt = r_flush_tot;
`endif

endmodule
